// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception/ERET sequencer: Cause.ExcCode
// values, exc_req bit positions, sequencer state encoding and CP0 addresses.
package cp0_exc_ctrl_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions inside exc_req
  localparam int EXC_BIT_ADEL_IF = 0;
  localparam int EXC_BIT_RI      = 1;
  localparam int EXC_BIT_OV      = 2;
  localparam int EXC_BIT_SYS     = 3;
  localparam int EXC_BIT_BP      = 4;
  localparam int EXC_BIT_ADEL_LD = 5;
  localparam int EXC_BIT_ADES    = 6;

  // CP0 register number of Status
  localparam logic [5:0] cp0addr_STATUS = 6'd12;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/cp0_exc_ctrl_prio.sv
// Combinational priority encoder: picks the highest-priority pending cause
// (interrupt first, then exc_req bit 0 upwards) and reports its ExcCode.
module cp0_exc_prio
  import cp0_exc_ctrl_pkg::*;
(
  input  logic       int_take,
  input  logic [6:0] exc_req,
  output logic       any,
  output logic [4:0] exc_code
);

  // Fixed-priority selection; exc_code is EXC_INT when nothing is pending
  always_comb begin
    any      = int_take | (|exc_req);
    exc_code = EXC_INT;
    if (int_take)                          exc_code = EXC_INT;
    else if (exc_req[EXC_BIT_ADEL_IF])     exc_code = EXC_ADEL;
    else if (exc_req[EXC_BIT_RI])          exc_code = EXC_RI;
    else if (exc_req[EXC_BIT_OV])          exc_code = EXC_OV;
    else if (exc_req[EXC_BIT_SYS])         exc_code = EXC_SYS;
    else if (exc_req[EXC_BIT_BP])          exc_code = EXC_BP;
    else if (exc_req[EXC_BIT_ADEL_LD])     exc_code = EXC_ADEL;
    else if (exc_req[EXC_BIT_ADES])        exc_code = EXC_ADES;
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer at the MEM->WB boundary. Issues the one-cycle
// exception strobe, owns Status.EXL, then flushes the pipe for FLUSH_CYCLES
// and emits a single-cycle fetch redirect to the vector or to EPC.
// Handshake: redirect_valid is a one-cycle strobe with no ready; the front
// end must accept it and must stall whenever busy is high.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  STATUS_ADDR  = cp0addr_STATUS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [6:0]  exc_req,
  input  logic        int_pending,
  input  logic        eret,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic [31:0] cp0_EPC_data,
  input  logic        mtc0_we,
  input  logic [5:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic        exception,
  output logic        EXL,
  output logic        BD,
  output logic [4:0]  exc_code,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] target_q;
  logic        exl_q;

  logic        int_take;
  logic        exc_any;
  logic [4:0]  prio_code;
  logic        in_idle;
  logic        take;
  logic        start_eret;
  logic        status_wr;

  // EPC is captured inside the CP0 register file, so wb_pc and the other
  // Status bits are not needed here
  logic        unused_inputs;
  assign unused_inputs = ^{wb_pc, mtc0_data[31:2], mtc0_data[0]};

  assign int_take   = int_pending & ~exl_q;
  assign in_idle    = (state == ST_IDLE);
  assign take       = in_idle & wb_valid & exc_any;
  assign start_eret = in_idle & eret & ~take;
  assign status_wr  = in_idle & mtc0_we & (cp0_addr == STATUS_ADDR);

  cp0_exc_prio u_prio (
    .int_take (int_take),
    .exc_req  (exc_req),
    .any      (exc_any),
    .exc_code (prio_code)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state: IDLE -> FLUSH on take/eret, FLUSH -> REDIR when count hits 0
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (take || start_eret) state_d = ST_FLUSH;
      ST_FLUSH: if (cnt_q == 4'd0)      state_d = ST_REDIR;
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flush counter: loaded on entry, counts down while flushing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cnt_q <= 4'd0;
    else if (take || start_eret)              cnt_q <= CNT_INIT;
    else if (state == ST_FLUSH && cnt_q != 0) cnt_q <= cnt_q - 4'd1;
  end

  // Redirect target: exception vector or the EPC seen with the ERET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          target_q <= 32'd0;
    else if (take)       target_q <= EXC_VECTOR;
    else if (start_eret) target_q <= cp0_EPC_data;
  end

  // Status.EXL: sequencer entry/exit outranks a same-cycle mtc0 write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          exl_q <= 1'b0;
    else if (take)       exl_q <= 1'b1;
    else if (start_eret) exl_q <= 1'b0;
    else if (status_wr)  exl_q <= mtc0_data[1];
  end

  // Outputs: strobes decoded from state; exception/BD/exc_code only on take
  always_comb begin
    exception      = take;
    BD             = take & wb_bd;
    exc_code       = take ? prio_code : 5'd0;
    EXL            = exl_q;
    flush          = (state != ST_IDLE);
    busy           = (state != ST_IDLE);
    redirect_valid = (state == ST_REDIR);
    redirect_pc    = (state == ST_REDIR) ? target_q : 32'd0;
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed vectors with literal checks, plus a
// per-cycle comparison against a behavioural model of the sequencer.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] VEC    = 32'hBFC00380;
  localparam int          FLUSHN = 2;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [6:0]  exc_req;
  logic        int_pending;
  logic        eret;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic [31:0] cp0_EPC_data;
  logic        mtc0_we;
  logic [5:0]  cp0_addr;
  logic [31:0] mtc0_data;
  logic        exception;
  logic        EXL;
  logic        BD;
  logic [4:0]  exc_code;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  cp0_exc_ctrl #(
    .EXC_VECTOR   (VEC),
    .FLUSH_CYCLES (FLUSHN),
    .STATUS_ADDR  (6'd12)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_valid       (wb_valid),
    .exc_req        (exc_req),
    .int_pending    (int_pending),
    .eret           (eret),
    .wb_pc          (wb_pc),
    .wb_bd          (wb_bd),
    .cp0_EPC_data   (cp0_EPC_data),
    .mtc0_we        (mtc0_we),
    .cp0_addr       (cp0_addr),
    .mtc0_data      (mtc0_data),
    .exception      (exception),
    .EXL            (EXL),
    .BD             (BD),
    .exc_code       (exc_code),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // busy_left counts the remaining busy cycles of a sequence; the last one
  // is the redirect cycle. exp_q holds the redirect target of the sequence.
  int          m_busy_left;
  logic        m_exl;
  logic [31:0] exp_q[$];

  function automatic logic [4:0] cause_code(input logic it, input logic [6:0] req);
    logic [4:0] codes [7];
    codes = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    if (it) return 5'd0;
    for (int i = 0; i < 7; i++) if (req[i]) return codes[i];
    return 5'd0;
  endfunction

  always @(negedge clk) begin
    logic       e_exc, e_bd, e_flush, e_busy, e_rv, it, tk;
    logic [4:0] e_code;
    if (!rst_n) begin
      m_busy_left = 0;
      m_exl       = 1'b0;
      exp_q.delete();
      check("rst_exception", exception, 0);
      check("rst_EXL", EXL, 0);
      check("rst_BD", BD, 0);
      check("rst_exc_code", exc_code, 0);
      check("rst_flush", flush, 0);
      check("rst_redirect_valid", redirect_valid, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_busy", busy, 0);
    end else begin
      it = 1'b0;
      tk = 1'b0;
      if (m_busy_left > 0) begin
        e_exc = 0; e_bd = 0; e_code = 0;
        e_flush = 1; e_busy = 1;
        e_rv = (m_busy_left == 1);
      end else begin
        it     = int_pending & ~m_exl;
        tk     = wb_valid & (it | (|exc_req));
        e_exc  = tk;
        e_bd   = tk & wb_bd;
        e_code = tk ? cause_code(it, exc_req) : 5'd0;
        e_flush = 0; e_busy = 0; e_rv = 0;
      end
      check("exception", exception, e_exc);
      check("BD", BD, e_bd);
      check("exc_code", exc_code, e_code);
      check("EXL", EXL, m_exl);
      check("flush", flush, e_flush);
      check("busy", busy, e_busy);
      check("redirect_valid", redirect_valid, e_rv);
      if (e_rv) begin
        if (exp_q.size() == 0) check("redirect_queue_empty", 1, 0);
        else check("redirect_pc", redirect_pc, exp_q.pop_front());
      end
      // advance the model across the coming edge
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else if (tk) begin
        m_exl = 1'b1;
        exp_q.push_back(VEC);
        m_busy_left = FLUSHN + 1;
      end else if (eret) begin
        m_exl = 1'b0;
        exp_q.push_back(cp0_EPC_data);
        m_busy_left = FLUSHN + 1;
      end else if (mtc0_we && cp0_addr == 6'd12) begin
        m_exl = mtc0_data[1];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    wb_valid = 0; exc_req = 0; int_pending = 0; eret = 0;
    wb_pc = 0; wb_bd = 0; cp0_EPC_data = 0;
    mtc0_we = 0; cp0_addr = 0; mtc0_data = 0;
  endtask

  task automatic write_status(input logic [31:0] d, input logic [5:0] a);
    mtc0_we = 1; cp0_addr = a; mtc0_data = d;
    tick;
    idle_inputs();
  endtask

  // after the take edge (already ticked once), run out the rest of the sequence
  task automatic finish_seq;
    repeat (3) tick;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [4:0] code_tbl [7];
    code_tbl = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("lit_reset_busy", busy, 0);
    check("lit_reset_EXL", EXL, 0);
    check("lit_reset_redirect_pc", redirect_pc, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;

    // Ov exception, full sequence timing
    wb_valid = 1; exc_req = 7'b0000100; wb_pc = 32'h80001000; wb_bd = 0;
    #1;
    check("lit_ov_exception", exception, 1);
    check("lit_ov_code", exc_code, 12);
    check("lit_ov_bd", BD, 0);
    tick; idle_inputs(); #1;
    check("lit_ov_c1_EXL", EXL, 1);
    check("lit_ov_c1_flush", flush, 1);
    check("lit_ov_c1_rv", redirect_valid, 0);
    tick;
    check("lit_ov_c2_flush", flush, 1);
    check("lit_ov_c2_rv", redirect_valid, 0);
    tick;
    check("lit_ov_c3_rv", redirect_valid, 1);
    check("lit_ov_c3_pc", redirect_pc, 32'hBFC00380);
    tick;
    check("lit_ov_c4_busy", busy, 0);

    // Priority with delay slot, then interrupt outranking everything
    write_status(32'h0, 6'd12);
    check("lit_clear_EXL", EXL, 0);
    wb_valid = 1; exc_req = 7'b1000011; wb_bd = 1;
    #1;
    check("lit_prio_code", exc_code, 4);
    check("lit_prio_bd", BD, 1);
    tick; idle_inputs(); finish_seq();
    write_status(32'h0, 6'd12);
    wb_valid = 1; exc_req = 7'b1000011; int_pending = 1;
    #1;
    check("lit_int_code", exc_code, 0);
    check("lit_int_exception", exception, 1);
    tick; idle_inputs(); finish_seq();

    // Interrupt masked by EXL, Sys still taken with EXL held
    wb_valid = 1; int_pending = 1; exc_req = 0;
    #1;
    check("lit_masked_exception", exception, 0);
    tick;
    check("lit_masked_flush", flush, 0);
    exc_req = 7'b0001000;
    #1;
    check("lit_sys_exception", exception, 1);
    check("lit_sys_code", exc_code, 8);
    tick;
    // inputs during FLUSH are ignored, including an mtc0 clearing EXL
    wb_valid = 1; exc_req = 7'b0000100; int_pending = 0;
    mtc0_we = 1; cp0_addr = 6'd12; mtc0_data = 32'h0;
    #1;
    check("lit_flush_ignore_exc", exception, 0);
    check("lit_sys_EXL", EXL, 1);
    tick; idle_inputs();
    repeat (2) tick;
    check("lit_flush_mtc0_ignored", EXL, 1);

    // ERET back to EPC
    cp0_EPC_data = 32'h80002004; eret = 1; wb_valid = 1;
    #1;
    check("lit_eret_exception", exception, 0);
    tick; idle_inputs(); #1;
    check("lit_eret_EXL", EXL, 0);
    check("lit_eret_flush", flush, 1);
    tick;
    check("lit_eret_c2_rv", redirect_valid, 0);
    tick;
    check("lit_eret_rv", redirect_valid, 1);
    check("lit_eret_pc", redirect_pc, 32'h80002004);
    tick;

    // ERET carrying RI: exception wins
    cp0_EPC_data = 32'h80002004; eret = 1; wb_valid = 1; exc_req = 7'b0000010;
    #1;
    check("lit_eret_ri_code", exc_code, 10);
    tick; idle_inputs(); #1;
    check("lit_eret_ri_EXL", EXL, 1);
    repeat (2) tick;
    check("lit_eret_ri_pc", redirect_pc, 32'hBFC00380);
    tick;

    // mtc0 Status writes
    write_status(32'h0, 6'd12);
    check("lit_mtc0_clear", EXL, 0);
    write_status(32'h2, 6'd12);
    check("lit_mtc0_set", EXL, 1);
    write_status(32'h0, 6'd13);
    check("lit_mtc0_other_addr", EXL, 1);
    mtc0_we = 1; cp0_addr = 6'd12; mtc0_data = 32'h2;
    eret = 1; cp0_EPC_data = 32'h80003000;
    tick; idle_inputs(); #1;
    check("lit_mtc0_vs_eret", EXL, 0);
    repeat (2) tick;
    check("lit_mtc0_eret_pc", redirect_pc, 32'h80003000);
    tick;

    // Every single cause in turn
    for (int i = 0; i < 7; i++) begin
      wb_valid = 1; exc_req = 7'(1 << i); wb_bd = i[0];
      #1;
      check("lit_single_code", exc_code, code_tbl[i]);
      tick; idle_inputs(); finish_seq();
    end

    // Reset in the first FLUSH cycle: no redirect afterwards
    wb_valid = 1; exc_req = 7'b0000100;
    tick; idle_inputs(); #1;
    check("lit_rst_pre_flush", flush, 1);
    rst_n = 1'b0;
    #1;
    check("lit_rst_flush", flush, 0);
    check("lit_rst_busy", busy, 0);
    check("lit_rst_EXL", EXL, 0);
    check("lit_rst_rv", redirect_valid, 0);
    repeat (2) tick;
    rst_n = 1'b1;
    repeat (5) begin
      tick;
      check("lit_post_rst_rv", redirect_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
